// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key schedule: starts from the round-10 key and steps backwards,
// emitting round keys NUM_ROUNDS..0 over a valid/ready stream.

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry i lives at byte position 255-i, which is ~i for an 8-bit index.
    assign out_o = SBOX_TABLE[{~in_i, 3'b000} +: 8];
endmodule

module inv_key_schedule #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {S_IDLE, S_OUT, S_SUB, S_STEP, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot_p3, sub_rot;

    assign {w0, w1, w2, w3} = key_q;
    assign p3     = w3 ^ w2;
    assign p2     = w2 ^ w1;
    assign p1     = w1 ^ w0;
    assign rot_p3 = {p3[23:0], p3[31:24]};

    // S-box inputs come straight from key_q, so they are stable through SUB and STEP.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .in_i  (rot_p3[8*gi +: 8]),
                .out_o (sub_rot[8*gi +: 8])
            );
        end
    endgenerate

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    assign p0 = w0 ^ sub_rot ^ rcon(idx_q - 4'd1);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    idx_d   = 4'(NUM_ROUNDS);
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = (idx_q == 4'd0) ? S_DONE : S_SUB;
                end
            end
            S_SUB: begin
                state_d = S_STEP;
            end
            S_STEP: begin
                key_d   = {p0, p1, p2, p3};
                idx_d   = idx_q - 4'd1;
                state_d = S_OUT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    assign round_key = key_q;
    assign round_idx = idx_q;
    assign key_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
endmodule
